// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, FSM states and datapath select encodings shared by the multi-cycle control unit.
// The JUMP state exists only when MC_JUMP_EN is defined.
package mc_pkg;

    localparam int unsigned OP_RTYPE = 0;
    localparam int unsigned OP_LW    = 1;
    localparam int unsigned OP_SW    = 2;
    localparam int unsigned OP_BEQ   = 3;
    localparam int unsigned OP_ADDI  = 4;
    localparam int unsigned OP_J     = 5;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_R_EXEC,
        ST_R_WB,
        ST_I_EXEC,
        ST_I_WB,
        ST_BRANCH,
`ifdef MC_JUMP_EN
        ST_JUMP,
`endif
        ST_TRAP
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       ext_op;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that hold until memory signals mem_ready.
    function automatic logic is_wait_state(state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts consecutive memory wait cycles; `expired` flags the wait cycle
// that would bring the count to MAX_WAIT, so the FSM can trap instead of waiting on.
module mc_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != FULL)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing a shared-memory MIPS-like multi-cycle datapath.
// Define MC_JUMP_EN to implement J via a JUMP state; otherwise J traps as illegal.
module multicycle_control #(
    parameter int OPCODE_W = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                ir_write,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic                ext_op,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic                mem_timeout
);

    import mc_pkg::*;

    localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] OPC_LW    = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] OPC_SW    = OPCODE_W'(OP_SW);
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] OPC_ADDI  = OPCODE_W'(OP_ADDI);
    localparam logic [OPCODE_W-1:0] OPC_J     = OPCODE_W'(OP_J);

    state_e state_q;
    state_e state_d;
    logic   illegal_op_q;
    logic   illegal_op_d;
    logic   mem_timeout_q;
    logic   mem_timeout_d;
    logic   timer_clear;
    logic   timer_enable;
    logic   timer_expired;
    ctrl_t  ctrl;

    // The branch decision is gated by zero in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    mc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    assign timer_enable = is_wait_state(state_q) && !mem_ready;
    assign timer_clear  = (state_d != state_q);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q       <= ST_FETCH;
            illegal_op_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            illegal_op_q  <= illegal_op_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d       = state_q;
        illegal_op_d  = illegal_op_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_FETCH, ST_MEM_RD, ST_MEM_WR: begin
                if (mem_ready) begin
                    case (state_q)
                        ST_FETCH:  state_d = ST_DECODE;
                        ST_MEM_RD: state_d = ST_MEM_WB;
                        default:   state_d = ST_FETCH;
                    endcase
                end else if (timer_expired) begin
                    state_d       = ST_TRAP;
                    mem_timeout_d = 1'b1;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OPC_RTYPE:      state_d = ST_R_EXEC;
                    OPC_LW, OPC_SW: state_d = ST_MEM_ADDR;
                    OPC_BEQ:        state_d = ST_BRANCH;
                    OPC_ADDI:       state_d = ST_I_EXEC;
`ifdef MC_JUMP_EN
                    OPC_J:          state_d = ST_JUMP;
`else
                    OPC_J: begin
                        state_d      = ST_TRAP;
                        illegal_op_d = 1'b1;
                    end
`endif
                    default: begin
                        state_d      = ST_TRAP;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                if (opcode == OPC_LW) begin
                    state_d = ST_MEM_RD;
                end else if (opcode == OPC_SW) begin
                    state_d = ST_MEM_WR;
                end else begin
                    state_d      = ST_TRAP;
                    illegal_op_d = 1'b1;
                end
            end
            ST_R_EXEC: state_d = ST_R_WB;
            ST_I_EXEC: state_d = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH: state_d = ST_FETCH;
`ifdef MC_JUMP_EN
            ST_JUMP:   state_d = ST_FETCH;
`endif
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Outputs follow the state only, except the fetch strobes that wait for memory.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_OP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                ST_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH2;
                    ctrl.ext_op    = 1'b1;
                    ctrl.alu_op    = ALU_OP_ADD;
                end
                ST_MEM_ADDR, ST_I_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.ext_op    = 1'b1;
                    ctrl.alu_op    = ALU_OP_ADD;
                end
                ST_MEM_RD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                ST_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                ST_MEM_WR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                ST_R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALU_OP_FUNCT;
                end
                ST_R_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                ST_I_WB: ctrl.reg_write = 1'b1;
                ST_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REG;
                    ctrl.alu_op        = ALU_OP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
`ifdef MC_JUMP_EN
                ST_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
`endif
                default: ctrl = '0;
            endcase
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign ext_op        = ctrl.ext_op;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = illegal_op_q && !rst;
    assign mem_timeout   = mem_timeout_q && !rst;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle checks of every control output of multicycle_control.
// Expectations follow MC_JUMP_EN the same way the design does.
module tb_multicycle_control;

    typedef enum {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_TRAP, S_RST
    } tb_state_e;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, mem_timeout;
    logic [18:0] obs;

    int checks_total  = 0;
    int checks_passed = 0;

    // Stimulus/expectation sequence for the scenario being run.
    logic [18:0] seq_exp [64];
    logic [18:0] seq_got [64];
    logic        seq_rdy [64];
    logic        seq_rst [64];
    int          seq_n;

    multicycle_control #(.OPCODE_W(4), .MAX_WAIT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .ext_op        (ext_op),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, ext_op, alu_src_b, alu_op, pc_source,
                  illegal_op, mem_timeout};

    // Output pattern each state must drive, written out from the state table.
    function automatic logic [18:0] exp_out(tb_state_e s, logic rdy, logic [1:0] fl);
        logic pcw = 0, pcwc = 0, irw = 0, io = 0, mr = 0, mw = 0, m2r = 0, rd = 0, rw = 0;
        logic asa = 0, ext = 0;
        logic [1:0] sb = 2'b00, ao = 2'b00, ps = 2'b00;
        case (s)
            S_FETCH:    begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE:   begin sb = 2'b11; ext = 1; end
            S_MEM_ADDR: begin asa = 1; sb = 2'b10; ext = 1; end
            S_MEM_RD:   begin mr = 1; io = 1; end
            S_MEM_WB:   begin rw = 1; m2r = 1; end
            S_MEM_WR:   begin mw = 1; io = 1; end
            S_R_EXEC:   begin asa = 1; ao = 2'b10; end
            S_R_WB:     begin rw = 1; rd = 1; end
            S_I_EXEC:   begin asa = 1; sb = 2'b10; ext = 1; end
            S_I_WB:     rw = 1;
            S_BRANCH:   begin asa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
            S_JUMP:     begin pcw = 1; ps = 2'b10; end
            default:    ;
        endcase
        return {pcw, pcwc, irw, io, mr, mw, m2r, rd, rw, asa, ext, sb, ao, ps, fl};
    endfunction

    task automatic clear_seq();
        seq_n = 0;
    endtask

    task automatic push(tb_state_e s, logic rdy, logic [1:0] fl = 2'b00, int times = 1);
        for (int k = 0; k < times; k++) begin
            seq_exp[seq_n] = exp_out(s, rdy, fl);
            seq_rdy[seq_n] = rdy;
            seq_rst[seq_n] = (s == S_RST);
            seq_n++;
        end
    endtask

    // Drives one step per cycle and captures outputs mid-cycle; leaves the last step un-clocked.
    task automatic play(logic [3:0] op, logic zb);
        for (int i = 0; i < seq_n; i++) begin
            opcode    = op;
            zero      = zb;
            mem_ready = seq_rdy[i];
            rst       = seq_rst[i];
            #1;
            seq_got[i] = obs;
            if (i < seq_n - 1) begin
                @(posedge clk);
                #2;
            end
        end
    endtask

    task automatic test_reset();
        clear_seq();
        push(S_RST, 1'b1);
        push(S_FETCH, 1'b0);
        play(4'd0, 1'b0);
        for (int i = 0; i < seq_n; i++) begin
            checks_total++;
            if (seq_got[i] !== seq_exp[i])
                $display("FAIL reset step %0d: got %b expected %b", i, seq_got[i], seq_exp[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_lw();
        clear_seq();
        push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_MEM_ADDR, 1'b1);
        push(S_MEM_RD, 1'b1); push(S_MEM_WB, 1'b1); push(S_FETCH, 1'b0);
        play(4'd1, 1'b0);
        for (int i = 0; i < seq_n; i++) begin
            checks_total++;
            if (seq_got[i] !== seq_exp[i])
                $display("FAIL lw step %0d: got %b expected %b", i, seq_got[i], seq_exp[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_rtype_wait();
        clear_seq();
        push(S_FETCH, 1'b0, 2'b00, 3); push(S_FETCH, 1'b1);
        push(S_DECODE, 1'b1); push(S_R_EXEC, 1'b1); push(S_R_WB, 1'b1); push(S_FETCH, 1'b0);
        play(4'd0, 1'b0);
        for (int i = 0; i < seq_n; i++) begin
            checks_total++;
            if (seq_got[i] !== seq_exp[i])
                $display("FAIL rtype_wait step %0d: got %b expected %b", i, seq_got[i], seq_exp[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_branch();
        for (int z = 0; z < 2; z++) begin
            clear_seq();
            push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_BRANCH, 1'b1); push(S_FETCH, 1'b0);
            play(4'd3, z[0]);
            for (int i = 0; i < seq_n; i++) begin
                checks_total++;
                if (seq_got[i] !== seq_exp[i])
                    $display("FAIL beq_zero%0d step %0d: got %b expected %b", z, i, seq_got[i], seq_exp[i]);
                else checks_passed++;
            end
        end
    endtask

    task automatic test_addi();
        clear_seq();
        push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_I_EXEC, 1'b1);
        push(S_I_WB, 1'b1); push(S_FETCH, 1'b0);
        play(4'd4, 1'b0);
        for (int i = 0; i < seq_n; i++) begin
            checks_total++;
            if (seq_got[i] !== seq_exp[i])
                $display("FAIL addi step %0d: got %b expected %b", i, seq_got[i], seq_exp[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_sw_ready_at_limit();
        clear_seq();
        push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_MEM_ADDR, 1'b1);
        push(S_MEM_WR, 1'b0, 2'b00, 14); push(S_MEM_WR, 1'b1); push(S_FETCH, 1'b0);
        play(4'd2, 1'b0);
        for (int i = 0; i < seq_n; i++) begin
            checks_total++;
            if (seq_got[i] !== seq_exp[i])
                $display("FAIL sw_ready_at_limit step %0d: got %b expected %b", i, seq_got[i], seq_exp[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_sw_timeout();
        clear_seq();
        push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_MEM_ADDR, 1'b1);
        push(S_MEM_WR, 1'b0, 2'b00, 15);
        push(S_TRAP, 1'b0, 2'b01); push(S_TRAP, 1'b1, 2'b01, 2);
        push(S_RST, 1'b0); push(S_FETCH, 1'b0);
        play(4'd2, 1'b0);
        for (int i = 0; i < seq_n; i++) begin
            checks_total++;
            if (seq_got[i] !== seq_exp[i])
                $display("FAIL sw_timeout step %0d: got %b expected %b", i, seq_got[i], seq_exp[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_illegal();
        clear_seq();
        push(S_FETCH, 1'b1); push(S_DECODE, 1'b1);
        push(S_TRAP, 1'b0, 2'b10); push(S_TRAP, 1'b1, 2'b10, 2);
        push(S_RST, 1'b1); push(S_FETCH, 1'b0);
        play(4'd7, 1'b0);
        for (int i = 0; i < seq_n; i++) begin
            checks_total++;
            if (seq_got[i] !== seq_exp[i])
                $display("FAIL illegal step %0d: got %b expected %b", i, seq_got[i], seq_exp[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_jump();
        clear_seq();
        push(S_FETCH, 1'b1); push(S_DECODE, 1'b1);
`ifdef MC_JUMP_EN
        push(S_JUMP, 1'b1); push(S_FETCH, 1'b0);
`else
        push(S_TRAP, 1'b1, 2'b10, 2); push(S_RST, 1'b0); push(S_FETCH, 1'b0);
`endif
        play(4'd5, 1'b0);
        for (int i = 0; i < seq_n; i++) begin
            checks_total++;
            if (seq_got[i] !== seq_exp[i])
                $display("FAIL jump step %0d: got %b expected %b", i, seq_got[i], seq_exp[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_rst_mid_instruction();
        clear_seq();
        push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_MEM_ADDR, 1'b1);
        push(S_MEM_RD, 1'b0); push(S_RST, 1'b1); push(S_FETCH, 1'b0);
        play(4'd1, 1'b0);
        for (int i = 0; i < seq_n; i++) begin
            checks_total++;
            if (seq_got[i] !== seq_exp[i])
                $display("FAIL rst_mid step %0d: got %b expected %b", i, seq_got[i], seq_exp[i]);
            else checks_passed++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 4'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        test_reset();
        test_lw();
        test_rtype_wait();
        test_branch();
        test_addi();
        test_sw_ready_at_limit();
        test_sw_timeout();
        test_illegal();
        test_jump();
        test_rst_mid_instruction();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
